// File: rtl/display_scan_scheduler.sv
// Refresh scheduler for a multiplexed 7-segment display: slot timing, blanking gap,
// digit select, frame-aligned double buffering and leading-zero suppression.
module display_scan_scheduler #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned NUM_DIGITS   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value,
  input  logic        lz_en,
  output logic [2:0]  digit_sel,
  output logic [7:0]  anodo,
  output logic [3:0]  nibble,
  output logic        frame_tick,
  output logic        pending
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK  = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       digit_next;
  logic             run;
  logic             slot_end;
  logic             wrap;
  logic             commit;
  logic             dark;
  logic [31:0]      active;
  logic [31:0]      shadow;
  logic [31:0]      active_next;
  logic [7:0]       zero_from;
  logic [7:0]       anodo_next;
  logic [3:0]       nibble_next;

  // Outputs always reflect the slot position reached by the edge; the first edge
  // after reset re-presents position 0 instead of advancing.
  always_comb begin : next_position
    slot_end   = run && (cnt == CNT_LAST);
    wrap       = slot_end && (digit_sel == DIGIT_LAST);
    cnt_next   = cnt;
    digit_next = digit_sel;
    if (slot_end) begin
      cnt_next   = '0;
      digit_next = wrap ? 3'd0 : digit_sel + 3'd1;
    end else if (run) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_comb begin : next_state
    state_next = state;
    if (cnt_next == '0) begin
      state_next = ST_BLANK;
    end else if (cnt_next == CNT_BLANK) begin
      state_next = ST_SHOW;
    end
  end

  // Frame-boundary commit is visible in the same cycle as frame_tick.
  always_comb begin : buffer_select
    commit      = wrap && pending;
    active_next = commit ? shadow : active;
  end

  // zero_from[i] is set when nibbles i..NUM_DIGITS-1 of the shown value are all zero.
  always_comb begin : lz_scan
    logic acc;
    acc       = 1'b1;
    zero_from = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      acc          = acc & (active_next[4*i +: 4] == 4'd0);
      zero_from[i] = acc;
    end
  end

  always_comb begin : output_decode
    dark        = lz_en && (digit_next != 3'd0) && zero_from[digit_next];
    nibble_next = active_next[{digit_next, 2'b00} +: 4];
    anodo_next  = 8'hFF;
    if ((state_next == ST_SHOW) && !dark) begin
      anodo_next[digit_next] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      run        <= 1'b0;
      cnt        <= '0;
      state      <= ST_BLANK;
      digit_sel  <= 3'd0;
      anodo      <= 8'hFF;
      nibble     <= 4'd0;
      frame_tick <= 1'b0;
      pending    <= 1'b0;
      active     <= '0;
      shadow     <= '0;
    end else begin
      run        <= 1'b1;
      cnt        <= cnt_next;
      state      <= state_next;
      digit_sel  <= digit_next;
      anodo      <= anodo_next;
      nibble     <= nibble_next;
      frame_tick <= wrap;
      active     <= active_next;
      // A load coinciding with a commit keeps pending set for the following frame.
      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
